// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
// Parametrised LED pattern generator. A step counter divides clk_FPGA down to
// one of two run-time selectable periods. Each period the LED pattern advances
// according to the selected display mode (rotate, bounce, fill or hold).
//
// Ports
//   clk_FPGA : board clock; all state changes on its rising edge
//   reset    : asynchronous, active-high reset
//   pause    : 1 freezes the step counter, the pattern and the bounce direction
//   rt       : direction, 0 = toward higher index, 1 = toward lower index
//   fast     : period select, 0 = TICK_SLOW, 1 = TICK_FAST
//   mode     : 00 rotate, 01 bounce, 10 fill, 11 hold
//   dout     : registered LED pattern (N_LED bits)
//   step     : registered pulse, high while dout shows a newly stepped value
// -----------------------------------------------------------------------------
module led_pattern_gen #(
  parameter int N_LED     = 5,
  parameter int TICK_SLOW = 25_000_000,
  parameter int TICK_FAST = 6_250_000
) (
  input  logic             clk_FPGA,
  input  logic             reset,
  input  logic             pause,
  input  logic             rt,
  input  logic             fast,
  input  logic [1:0]       mode,
  output logic [N_LED-1:0] dout,
  output logic             step
);

  localparam int TICK_MAX = (TICK_SLOW > TICK_FAST) ? TICK_SLOW : TICK_FAST;
  localparam int CNT_W    = $clog2(TICK_MAX);

  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(TICK_SLOW - 32'sd1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(TICK_FAST - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);

  localparam logic [N_LED-1:0] LSB_ONE  = {{(N_LED-1){1'b0}}, 1'b1};
  localparam logic [N_LED-1:0] MSB_ONE  = {1'b1, {(N_LED-1){1'b0}}};
  localparam logic [N_LED-1:0] ALL_ONES = {N_LED{1'b1}};
  localparam logic [N_LED-1:0] ALL_ZERO = {N_LED{1'b0}};

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_FILL   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  // Registered state and its next-state values
  mode_e             mode_q,   mode_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [N_LED-1:0]  dout_q,   dout_d;
  logic              step_q,   step_d;
  logic              dir_up_q, dir_up_d;

  // Combinational helpers
  mode_e             mode_in_s;
  logic              mode_chg_s;
  logic [CNT_W-1:0]  last_s;
  logic              tick_s;
  logic [N_LED-1:0]  start_s;
  logic [N_LED-1:0]  pat_next_s;
  logic              dir_next_s;

  assign mode_in_s  = mode_e'(mode);
  assign mode_chg_s = (mode_in_s != mode_q);
  assign last_s     = fast ? FAST_LAST : SLOW_LAST;
  // >= rather than == so that shortening the period mid-count never overruns
  assign tick_s     = !pause && (cnt_q >= last_s);
  // Fill toward lower index starts from the MSB; every other mode from bit 0
  assign start_s    = ((mode_in_s == MODE_FILL) && rt) ? MSB_ONE : LSB_ONE;

  // Pattern the current mode would show after one step
  always_comb begin
    pat_next_s = dout_q;
    dir_next_s = dir_up_q;
    case (mode_q)
      MODE_ROTATE: begin
        if (rt) begin
          pat_next_s = {dout_q[0], dout_q[N_LED-1:1]};
        end else begin
          pat_next_s = {dout_q[N_LED-2:0], dout_q[N_LED-1]};
        end
      end
      MODE_BOUNCE: begin
        // At an end LED the step turns around, so the end is lit for one step
        if (dir_up_q) begin
          if (dout_q[N_LED-1]) begin
            pat_next_s = {1'b0, dout_q[N_LED-1:1]};
            dir_next_s = 1'b0;
          end else begin
            pat_next_s = {dout_q[N_LED-2:0], 1'b0};
            dir_next_s = 1'b1;
          end
        end else begin
          if (dout_q[0]) begin
            pat_next_s = {dout_q[N_LED-2:0], 1'b0};
            dir_next_s = 1'b1;
          end else begin
            pat_next_s = {1'b0, dout_q[N_LED-1:1]};
            dir_next_s = 1'b0;
          end
        end
      end
      MODE_FILL: begin
        // Lit LEDs stay lit; the shifted copy with an inserted 1 lights the
        // next LED from the insertion side, so changing rt mid-fill simply
        // starts filling from the other end.
        if (dout_q == ALL_ONES) begin
          pat_next_s = ALL_ZERO;
        end else if (rt) begin
          pat_next_s = dout_q | {1'b1, dout_q[N_LED-1:1]};
        end else begin
          pat_next_s = dout_q | {dout_q[N_LED-2:0], 1'b1};
        end
      end
      MODE_HOLD: begin
        pat_next_s = dout_q;
      end
      default: begin
        pat_next_s = dout_q;
      end
    endcase
  end

  // Next-state selection: mode change beats pause, pause beats tick
  always_comb begin
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    step_d   = 1'b0;
    dir_up_d = dir_up_q;
    if (mode_chg_s) begin
      mode_d   = mode_in_s;
      cnt_d    = CNT_ZERO;
      dout_d   = start_s;
      dir_up_d = 1'b1;
    end else if (pause) begin
      step_d = 1'b0;
    end else if (tick_s) begin
      cnt_d    = CNT_ZERO;
      dout_d   = pat_next_s;
      dir_up_d = dir_next_s;
      // Hold consumes ticks without presenting a new value
      step_d   = (mode_q != MODE_HOLD);
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clk_FPGA or posedge reset) begin
    if (reset) begin
      mode_q   <= MODE_ROTATE;
      cnt_q    <= CNT_ZERO;
      dout_q   <= LSB_ONE;
      step_q   <= 1'b0;
      dir_up_q <= 1'b1;
    end else begin
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      step_q   <= step_d;
      dir_up_q <= dir_up_d;
    end
  end

  assign dout = dout_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
// Directed bench for led_pattern_gen (N_LED=5, TICK_SLOW=8, TICK_FAST=2).
// A behavioural model tracks the expected LED state (LED index for rotate,
// phase within the bounce sweep, "light the next dark LED" for fill) and is
// compared against dout/step after every clock edge and on async reset.
// Literal expectations taken from hand-worked sequences pin the model.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;

  localparam int N  = 5;
  localparam int TS = 8;
  localparam int TF = 2;

  logic         clk_FPGA = 1'b0;
  logic         reset;
  logic         pause;
  logic         rt;
  logic         fast;
  logic [1:0]   mode;
  logic [N-1:0] dout;
  logic         step;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Model state
  int           m_cnt;
  int           m_per;
  int           m_pos;
  int           m_phase;
  logic [1:0]   m_mode;
  logic [N-1:0] m_dout;
  logic         m_step;

  logic [N-1:0] rot_l [0:4] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
  logic [N-1:0] rot_r [0:4] = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
  logic [N-1:0] bnc   [0:8] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000,
                                5'b00100, 5'b00010, 5'b00001, 5'b00010};
  logic [N-1:0] fl    [0:7] = '{5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b00000,
                                5'b00001, 5'b00011, 5'b00111};
  logic [N-1:0] fr    [0:3] = '{5'b10111, 5'b11111, 5'b00000, 5'b10000};

  led_pattern_gen #(.N_LED(N), .TICK_SLOW(TS), .TICK_FAST(TF)) dut (
    .clk_FPGA (clk_FPGA),
    .reset    (reset),
    .pause    (pause),
    .rt       (rt),
    .fast     (fast),
    .mode     (mode),
    .dout     (dout),
    .step     (step)
  );

  always #5 clk_FPGA = ~clk_FPGA;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [N-1:0] ed, input logic es);
    check({name, " dout"}, dout, ed);
    check({name, " step"}, {{(N-1){1'b0}}, step}, {{(N-1){1'b0}}, es});
  endtask

  // Light the next dark LED counting from the insertion side; all lit -> all dark
  function automatic logic [N-1:0] fill_next(input logic [N-1:0] v, input logic right);
    logic [N-1:0] r;
    bit done;
    r = v;
    done = 1'b0;
    if (v == {N{1'b1}}) begin
      r = '0;
    end else if (!right) begin
      for (int i = 0; i < N; i++) begin
        if (!done && !v[i]) begin r[i] = 1'b1; done = 1'b1; end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (!done && !v[i]) begin r[i] = 1'b1; done = 1'b1; end
      end
    end
    return r;
  endfunction

  // Model update on every edge / reset, then compare shortly after
  initial forever begin
    @(posedge clk_FPGA or posedge reset);
    if (reset) begin
      m_cnt = 0; m_mode = 2'b00; m_pos = 0; m_phase = 0; m_dout = 5'b00001; m_step = 1'b0;
    end else if (mode != m_mode) begin
      m_mode = mode; m_cnt = 0; m_step = 1'b0; m_pos = 0; m_phase = 0;
      m_dout = (mode == 2'b10 && rt) ? 5'b10000 : 5'b00001;
    end else if (pause) begin
      m_step = 1'b0;
    end else begin
      m_per = fast ? TF : TS;
      if (m_cnt >= m_per - 1) begin
        m_cnt  = 0;
        m_step = (m_mode != 2'b11);
        case (m_mode)
          2'b00: begin
            m_pos  = rt ? (m_pos + N - 1) % N : (m_pos + 1) % N;
            m_dout = 5'b00001 << m_pos;
          end
          2'b01: begin
            m_phase = (m_phase + 1) % (2 * N - 2);
            m_pos   = (m_phase < N) ? m_phase : (2 * N - 2 - m_phase);
            m_dout  = 5'b00001 << m_pos;
          end
          2'b10: m_dout = fill_next(m_dout, rt);
          default: ;
        endcase
      end else begin
        m_cnt  = m_cnt + 1;
        m_step = 1'b0;
      end
    end
    #1;
    if (chk_en) begin
      check("model dout", dout, m_dout);
      check("model step", {{(N-1){1'b0}}, step}, {{(N-1){1'b0}}, m_step});
    end
  end

  initial begin
    reset = 1'b0; pause = 1'b0; rt = 1'b0; fast = 1'b0; mode = 2'b00;
    #2;
    chk_en = 1'b1;
    reset  = 1'b1;
    repeat (2) @(negedge clk_FPGA);
    reset = 1'b0;

    // 1. rotate left, then right
    repeat (7) @(negedge clk_FPGA);
    lit("rot pre-first", 5'b00001, 1'b0);
    @(negedge clk_FPGA);
    lit("rot first", rot_l[0], 1'b1);
    for (int k = 1; k < 5; k++) begin
      repeat (8) @(negedge clk_FPGA);
      lit("rot left", rot_l[k], 1'b1);
    end
    rt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      repeat (8) @(negedge clk_FPGA);
      lit("rot right", rot_r[k], 1'b1);
    end

    // 2. bounce, rt toggling ignored
    mode = 2'b01;
    @(negedge clk_FPGA);
    lit("bounce reload", 5'b00001, 1'b0);
    for (int k = 0; k < 9; k++) begin
      rt = ~rt;
      repeat (8) @(negedge clk_FPGA);
      lit("bounce", bnc[k], 1'b1);
    end

    // 3. fill left, then switch insertion side at 00111
    mode = 2'b10; rt = 1'b0;
    @(negedge clk_FPGA);
    lit("fill reload", 5'b00001, 1'b0);
    for (int k = 0; k < 8; k++) begin
      repeat (8) @(negedge clk_FPGA);
      lit("fill left", fl[k], 1'b1);
    end
    rt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (8) @(negedge clk_FPGA);
      lit("fill right", fr[k], 1'b1);
    end

    // 4. pause at counter=3 for 20 cycles, then mode change while paused
    repeat (3) @(negedge clk_FPGA);
    pause = 1'b1;
    repeat (20) @(negedge clk_FPGA);
    lit("pause hold", 5'b10000, 1'b0);
    pause = 1'b0;
    repeat (4) @(negedge clk_FPGA);
    lit("pause resume early", 5'b10000, 1'b0);
    @(negedge clk_FPGA);
    lit("pause resume step", 5'b11000, 1'b1);
    pause = 1'b1; mode = 2'b00;
    @(negedge clk_FPGA);
    lit("paused reload", 5'b00001, 1'b0);
    repeat (3) @(negedge clk_FPGA);
    lit("paused reload held", 5'b00001, 1'b0);

    // 5. fast period, and slow->fast switch at counter=5
    pause = 1'b0; fast = 1'b1; rt = 1'b0;
    repeat (2) @(negedge clk_FPGA);
    lit("fast step1", 5'b00010, 1'b1);
    repeat (2) @(negedge clk_FPGA);
    lit("fast step2", 5'b00100, 1'b1);
    fast = 1'b0;
    repeat (5) @(negedge clk_FPGA);
    lit("slow mid", 5'b00100, 1'b0);
    fast = 1'b1;
    @(negedge clk_FPGA);
    lit("fast switch tick", 5'b01000, 1'b1);

    // 6. async reset mid-pattern, then mode change colliding with a tick
    mode = 2'b01;
    @(negedge clk_FPGA);
    lit("bounce fast reload", 5'b00001, 1'b0);
    repeat (6) @(negedge clk_FPGA);
    lit("bounce fast", 5'b01000, 1'b1);
    @(negedge clk_FPGA);
    #2;
    reset = 1'b1;
    #1;
    lit("async reset", 5'b00001, 1'b0);
    @(negedge clk_FPGA);
    reset = 1'b0; mode = 2'b00;
    @(negedge clk_FPGA);
    mode = 2'b10; rt = 1'b1;
    @(negedge clk_FPGA);
    lit("reload beats tick", 5'b10000, 1'b0);
    repeat (2) @(negedge clk_FPGA);
    lit("fill after reload", 5'b11000, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
